// File: rtl/mdsp_pkg.sv
// -----------------------------------------------------------------------------
// mdsp_pkg
// Shared types for the multi-channel DSP front end: sample width, the signed
// sample type and the issue-scheduler state encoding.
// -----------------------------------------------------------------------------
package mdsp_pkg;

  localparam int MDSP_DATA_BITS = 24;

  typedef logic signed [MDSP_DATA_BITS-1:0] mdsp_sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/mdsp_tag_fifo.sv
// -----------------------------------------------------------------------------
// mdsp_tag_fifo
// Synchronous FIFO of channel tags. It records which channel owns each sample
// currently inside the DSP core, so results can be routed back in order.
//
// Ports
//   clk_i     in   system clock
//   rst_i     in   synchronous reset, active-high (empties the FIFO)
//   push_i    in   write push_tag_i (taken when not full, or when popping)
//   push_tag_i in  tag to store
//   pop_i     in   remove the head entry (ignored when empty)
//   pop_tag_o out  head entry, valid whenever empty_o=0
//   full_o    out  FIFO holds DEPTH tags
//   empty_o   out  FIFO holds no tags
// -----------------------------------------------------------------------------
module mdsp_tag_fifo #(
  parameter int DEPTH    = 8,
  parameter int TAG_BITS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [TAG_BITS-1:0] push_tag_i,
  input  logic                pop_i,
  output logic [TAG_BITS-1:0] pop_tag_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [TAG_BITS-1:0] mem_reg [DEPTH];
  // One extra MSB acts as a wrap bit: equal pointers mean empty, pointers
  // differing only in the wrap bit mean full.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  assign empty_o   = (wr_ptr_reg == rd_ptr_reg);
  assign full_o    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop    = pop_i && !empty_o;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push   = push_i && (!full_o || do_pop);
  // The head is read without a register stage so a result can be routed in
  // the cycle it arrives; the store is small enough for distributed memory.
  assign pop_tag_o = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= push_tag_i;
  end

endmodule

// File: rtl/mdsp_chan_sched.sv
// -----------------------------------------------------------------------------
// mdsp_chan_sched
// Time-shares one microcoded DSP core between G_CHANNELS sample streams.
// Each channel has a one-entry pending buffer; a round-robin picker feeds the
// core's x port, the issued channel is pushed as a tag, and each core result
// is routed back to the channel at the head of the tag FIFO.
//
// Optional feature macro: MDSP_CHAN_SCHED_PRIO_EN
//   defined   -> adds ch_prio_i; pending priority channels are served first
//                (round-robin among themselves), the rest only when no
//                priority channel is pending.
//   undefined -> pure round-robin, no ch_prio_i port.
//
// Ports
//   clk_i          in   system clock
//   rst_i          in   synchronous reset, active-high
//   ch_x_i         in   per-channel samples, channel k at [W*k+W-1:W*k]
//   ch_x_valid_i   in   per-channel 1-cycle sample strobe
//   ch_prio_i      in   per-channel priority (only with the macro defined)
//   ch_ovf_o       out  sticky per-channel overflow (sample overwritten)
//   ch_ovf_clr_i   in   clears the matching overflow flag
//   dsp_x_req_i    in   core requests an input sample
//   dsp_x_valid_o  out  1-cycle sample valid to the core
//   dsp_x_o        out  sample data to the core
//   dsp_y_valid_i  in   core result strobe
//   dsp_y_i        in   core result data
//   dsp_y_req_o    out  result acceptance (a tag is outstanding)
//   ch_y_o         out  per-channel result, held until the next one
//   ch_y_valid_o   out  per-channel 1-cycle result strobe
//   tag_err_o      out  sticky: result arrived with no outstanding tag
// -----------------------------------------------------------------------------
module mdsp_chan_sched
  import mdsp_pkg::*;
#(
  parameter int G_CHANNELS  = 4,
  parameter int G_DATA_BITS = MDSP_DATA_BITS,
  parameter int G_TAG_DEPTH = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [G_CHANNELS*G_DATA_BITS-1:0] ch_x_i,
  input  logic [G_CHANNELS-1:0]             ch_x_valid_i,
`ifdef MDSP_CHAN_SCHED_PRIO_EN
  input  logic [G_CHANNELS-1:0]             ch_prio_i,
`endif
  output logic [G_CHANNELS-1:0]             ch_ovf_o,
  input  logic [G_CHANNELS-1:0]             ch_ovf_clr_i,
  input  logic                              dsp_x_req_i,
  output logic                              dsp_x_valid_o,
  output logic [G_DATA_BITS-1:0]            dsp_x_o,
  input  logic                              dsp_y_valid_i,
  input  logic [G_DATA_BITS-1:0]            dsp_y_i,
  output logic                              dsp_y_req_o,
  output logic [G_CHANNELS*G_DATA_BITS-1:0] ch_y_o,
  output logic [G_CHANNELS-1:0]             ch_y_valid_o,
  output logic                              tag_err_o
);

  localparam int TW = $clog2(G_CHANNELS);

  sched_state_t          state_reg, state_next;
  logic [TW-1:0]         rr_ptr_reg;
  logic [G_CHANNELS-1:0] pend_reg;
  logic [G_CHANNELS-1:0] ovf_reg;
  logic [G_CHANNELS-1:0] ch_y_valid_reg;
  logic [G_DATA_BITS-1:0] x_buf_reg [G_CHANNELS];
  logic [G_DATA_BITS-1:0] ch_y_reg  [G_CHANNELS];
  logic [G_DATA_BITS-1:0] dsp_x_reg;
  logic                  tag_err_reg;

  logic [G_CHANNELS-1:0] elig;
  logic [TW-1:0]         grant_idx;
  logic                  grant_found;
  logic                  grant_go;
  logic                  tag_full, tag_empty;
  logic [TW-1:0]         pop_tag;
  logic                  y_pop, y_err;

  // Eligible set for the picker: priority channels mask out the rest when any
  // of them is pending.
`ifdef MDSP_CHAN_SCHED_PRIO_EN
  assign elig = (|(pend_reg & ch_prio_i)) ? (pend_reg & ch_prio_i) : pend_reg;
`else
  assign elig = pend_reg;
`endif

  // First eligible channel scanning upward from rr_ptr, wrapping at G_CHANNELS.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < G_CHANNELS; i++) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= G_CHANNELS) idx = idx - G_CHANNELS;
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        grant_idx   = TW'(idx);
      end
    end
  end

  assign grant_go = (state_reg == IDLE) && dsp_x_req_i && grant_found && !tag_full;
  assign y_pop    = dsp_y_valid_i && !tag_empty;
  assign y_err    = dsp_y_valid_i && tag_empty;

  always_comb begin
    state_next    = state_reg;
    dsp_x_valid_o = 1'b0;
    case (state_reg)
      IDLE:    if (grant_go) state_next = ISSUE;
      ISSUE: begin
        dsp_x_valid_o = 1'b1;
        state_next    = HOLD;
      end
      HOLD:    state_next = IDLE;  // gives the core a cycle to drop its request
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      dsp_x_reg      <= '0;
      tag_err_reg    <= 1'b0;
      pend_reg       <= '0;
      ovf_reg        <= '0;
      ch_y_valid_reg <= '0;
      for (int k = 0; k < G_CHANNELS; k++) begin
        x_buf_reg[k] <= '0;
        ch_y_reg[k]  <= '0;
      end
    end else begin
      state_reg <= state_next;
      if (grant_go) begin
        dsp_x_reg  <= x_buf_reg[grant_idx];
        rr_ptr_reg <= (grant_idx == TW'(G_CHANNELS - 1)) ? '0 : grant_idx + TW'(1);
      end
      if (y_err) tag_err_reg <= 1'b1;
      for (int k = 0; k < G_CHANNELS; k++) begin
        // A new sample always wins over a grant on the same channel, leaving
        // the buffer pending with fresh data.
        if (ch_x_valid_i[k]) begin
          x_buf_reg[k] <= ch_x_i[k*G_DATA_BITS +: G_DATA_BITS];
          pend_reg[k]  <= 1'b1;
        end else if (grant_go && grant_idx == TW'(k)) begin
          pend_reg[k]  <= 1'b0;
        end
        // Overwrite without a same-cycle grant is an overflow; set beats clear.
        if (ch_x_valid_i[k] && pend_reg[k] && !(grant_go && grant_idx == TW'(k)))
          ovf_reg[k] <= 1'b1;
        else if (ch_ovf_clr_i[k])
          ovf_reg[k] <= 1'b0;
        ch_y_valid_reg[k] <= y_pop && (pop_tag == TW'(k));
        if (y_pop && pop_tag == TW'(k)) ch_y_reg[k] <= dsp_y_i;
      end
    end
  end

  mdsp_tag_fifo #(
    .DEPTH    (G_TAG_DEPTH),
    .TAG_BITS (TW)
  ) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (grant_go),
    .push_tag_i (grant_idx),
    .pop_i      (y_pop),
    .pop_tag_o  (pop_tag),
    .full_o     (tag_full),
    .empty_o    (tag_empty)
  );

  assign dsp_x_o      = dsp_x_reg;
  assign dsp_y_req_o  = !tag_empty;
  assign ch_ovf_o     = ovf_reg;
  assign ch_y_valid_o = ch_y_valid_reg;
  assign tag_err_o    = tag_err_reg;

  for (genvar gi = 0; gi < G_CHANNELS; gi++) begin : g_ch_y
    assign ch_y_o[gi*G_DATA_BITS +: G_DATA_BITS] = ch_y_reg[gi];
  end

endmodule

// File: tb/tb_mdsp_chan_sched.sv
// -----------------------------------------------------------------------------
// tb_mdsp_chan_sched
// Directed bench for mdsp_chan_sched with a simple core model (y = x+1 after
// 6 cycles). Stimulus pushes expected issues/results into queues; independent
// monitors pop and compare whenever the DUT presents an issue or a result.
// -----------------------------------------------------------------------------
module tb_mdsp_chan_sched;

  localparam int NCH = 4;
  localparam int W   = 24;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [NCH*W-1:0]   ch_x_i = '0;
  logic [NCH-1:0]     ch_x_valid_i = '0;
  logic [NCH-1:0]     ch_ovf_o;
  logic [NCH-1:0]     ch_ovf_clr_i = '0;
  logic               dsp_x_req_i = 1'b0;
  logic               dsp_x_valid_o;
  logic [W-1:0]       dsp_x_o;
  logic               dsp_y_valid_i = 1'b0;
  logic [W-1:0]       dsp_y_i = '0;
  logic               dsp_y_req_o;
  logic [NCH*W-1:0]   ch_y_o;
  logic [NCH-1:0]     ch_y_valid_o;
  logic               tag_err_o;
`ifdef MDSP_CHAN_SCHED_PRIO_EN
  logic [NCH-1:0]     ch_prio_i = '0;
`endif

  always #5 clk_i = ~clk_i;

  mdsp_chan_sched #(
    .G_CHANNELS  (NCH),
    .G_DATA_BITS (W),
    .G_TAG_DEPTH (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ch_x_i        (ch_x_i),
    .ch_x_valid_i  (ch_x_valid_i),
`ifdef MDSP_CHAN_SCHED_PRIO_EN
    .ch_prio_i     (ch_prio_i),
`endif
    .ch_ovf_o      (ch_ovf_o),
    .ch_ovf_clr_i  (ch_ovf_clr_i),
    .dsp_x_req_i   (dsp_x_req_i),
    .dsp_x_valid_o (dsp_x_valid_o),
    .dsp_x_o       (dsp_x_o),
    .dsp_y_valid_i (dsp_y_valid_i),
    .dsp_y_i       (dsp_y_i),
    .dsp_y_req_o   (dsp_y_req_o),
    .ch_y_o        (ch_y_o),
    .ch_y_valid_o  (ch_y_valid_o),
    .tag_err_o     (tag_err_o)
  );

  typedef struct { int ch; logic [W-1:0] d; } res_t;
  typedef struct { int t;  logic [W-1:0] x; } core_t;

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [W-1:0] exp_iss_q [$];
  res_t         exp_res_q [$];
  core_t        core_q    [$];
  int           issue_cyc [$];
  int           issue_cnt = 0;
  int           pulse_cnt = 0;
  bit           core_req  = 1'b0;
  bit           core_y_en = 1'b1;
  bit           inj_y     = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Core model: captures issued samples, answers y = x+1 six cycles later.
  initial begin
    core_t c;
    forever begin
      @(negedge clk_i);
      if (dsp_x_valid_o) core_q.push_back('{cyc + 6, dsp_x_o});
      dsp_x_req_i = core_req;
      if (inj_y) begin
        dsp_y_valid_i = 1'b1;
        dsp_y_i       = 24'h000555;
        inj_y         = 1'b0;
      end else if (core_y_en && core_q.size() > 0 && core_q[0].t <= cyc) begin
        c             = core_q.pop_front();
        dsp_y_valid_i = 1'b1;
        dsp_y_i       = c.x + 24'd1;
      end else begin
        dsp_y_valid_i = 1'b0;
      end
    end
  end

  // Issue monitor.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk_i);
      if (dsp_x_valid_o) begin
        issue_cnt++;
        issue_cyc.push_back(cyc);
        if (exp_iss_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL issue_unexpected: got x=%0h required no issue", dsp_x_o);
        end else begin
          e = exp_iss_q.pop_front();
          chk("issue_x", 32'(dsp_x_o), 32'(e));
        end
      end
    end
  end

  // Result monitor.
  initial begin
    res_t r;
    forever begin
      @(negedge clk_i);
      for (int k = 0; k < NCH; k++) begin
        if (ch_y_valid_o[k]) begin
          pulse_cnt++;
          if (exp_res_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL result_unexpected: got ch=%0d y=%0h required no result", k, ch_y_o[k*W +: W]);
          end else begin
            r = exp_res_q.pop_front();
            chk("res_chan", 32'(k), 32'(r.ch));
            chk("res_data", 32'(ch_y_o[k*W +: W]), 32'(r.d));
          end
        end
      end
    end
  end

  task automatic put(input int k, input logic [W-1:0] d, input bit expect_it);
    ch_x_i[k*W +: W] = d;
    ch_x_valid_i[k]  = 1'b1;
    if (expect_it) begin
      exp_iss_q.push_back(d);
      exp_res_q.push_back('{k, d + 24'd1});
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    ch_x_valid_i = '0;
    ch_ovf_clr_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i    = 1'b1;
    core_req = 1'b0;
    repeat (2) @(negedge clk_i);
    exp_iss_q.delete();
    exp_res_q.delete();
    core_q.delete();
    core_y_en = 1'b1;
    rst_i     = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_iss_q.size() == 0 && exp_res_q.size() == 0 && !dsp_y_req_o) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d issues/%0d results pending required 0", name,
               exp_iss_q.size(), exp_res_q.size());
    end
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, p0, n;

    // Reset state.
    repeat (3) @(negedge clk_i);
    chk("rst_x_valid", 32'(dsp_x_valid_o), 0);
    chk("rst_x_data",  32'(dsp_x_o), 0);
    chk("rst_y_req",   32'(dsp_y_req_o), 0);
    chk("rst_ch_y_any", 32'(|ch_y_o), 0);
    chk("rst_y_valid", 32'(ch_y_valid_o), 0);
    chk("rst_ovf",     32'(ch_ovf_o), 0);
    chk("rst_tag_err", 32'(tag_err_o), 0);
    rst_i = 1'b0;

    // Single channel round trip.
    core_req = 1'b1;
    p0 = pulse_cnt;
    put(0, 24'h000123, 1'b1);
    tick();
    wait_drain("t1", 100);
    chk("t1_ch_y0", 32'(ch_y_o[0 +: W]), 32'h000124);
    chk("t1_y_req", 32'(dsp_y_req_o), 0);
    chk("t1_pulses", 32'(pulse_cnt - p0), 1);

    // All four channels at once: order 0..3, issues 3 cycles apart.
    do_reset();
    core_req = 1'b1;
    base = issue_cyc.size();
    for (int k = 0; k < NCH; k++) put(k, 24'h000100 + 24'(k), 1'b1);
    tick();
    wait_drain("t2", 200);
    for (int i = 0; i < 3; i++)
      chk("t2_spacing", 32'(issue_cyc[base + i + 1] - issue_cyc[base + i]), 3);

    // Overflow on channel 2: second sample is issued, clear drops the flag.
    do_reset();
    put(2, 24'h000AAA, 1'b0);
    tick();
    put(2, 24'h000BBB, 1'b1);
    tick();
    tick();
    chk("t3_ovf_set", 32'(ch_ovf_o), 32'h4);
    core_req = 1'b1;
    wait_drain("t3", 100);
    chk("t3_ovf_sticky", 32'(ch_ovf_o), 32'h4);
    ch_ovf_clr_i[2] = 1'b1;
    tick();
    chk("t3_ovf_clr", 32'(ch_ovf_o), 0);

    // Tag FIFO full: 9 samples, core withholds results, only 8 issue.
    do_reset();
    core_y_en = 1'b0;
    core_req  = 1'b1;
    base = issue_cnt;
    for (int i = 0; i < 9; i++) begin
      put(i % NCH, 24'h000200 + 24'(i), 1'b1);
      repeat (4) tick();
    end
    repeat (10) tick();
    chk("t4_issued_while_full", 32'(issue_cnt - base), 8);
    chk("t4_y_req", 32'(dsp_y_req_o), 1);
    chk("t4_x_valid_low", 32'(dsp_x_valid_o), 0);
    chk("t4_no_ovf", 32'(ch_ovf_o), 0);
    core_y_en = 1'b1;
    wait_drain("t4", 300);
    chk("t4_issued_total", 32'(issue_cnt - base), 9);

    // Result with no outstanding tag.
    do_reset();
    p0 = pulse_cnt;
    inj_y = 1'b1;
    repeat (5) tick();
    chk("t5_tag_err", 32'(tag_err_o), 1);
    chk("t5_no_pulse", 32'(pulse_cnt - p0), 0);

    // Reset with three samples in flight.
    do_reset();
    core_y_en = 1'b0;
    core_req  = 1'b1;
    base = issue_cnt;
    for (int k = 0; k < 3; k++) put(k, 24'h000300 + 24'(k), 1'b1);
    tick();
    n = 0;
    while (issue_cnt - base < 3 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL t6_issue_timeout: got %0d issues required 3", issue_cnt - base);
    end
    core_req = 1'b0;
    rst_i    = 1'b1;
    @(negedge clk_i);
    chk("t6_x_valid", 32'(dsp_x_valid_o), 0);
    chk("t6_x_data",  32'(dsp_x_o), 0);
    chk("t6_y_req",   32'(dsp_y_req_o), 0);
    chk("t6_y_valid", 32'(ch_y_valid_o), 0);
    chk("t6_tag_err", 32'(tag_err_o), 0);
    rst_i = 1'b0;
    exp_res_q.delete();
    p0 = pulse_cnt;
    core_y_en = 1'b1;
    n = 0;
    while (core_q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("t6_late_y_err", 32'(tag_err_o), 1);
    chk("t6_no_pulse", 32'(pulse_cnt - p0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
